ims1420_arbiter: RTL
====================

// Module: ims1420_arbiter
// PURPOSE
//  Shares one ims1420 4Kx4 SRAM between NUM_REQ requesters, e.g. CPU bus and video fetch.
//  - Per-port req/ack handshake; round-robin arbitration.
//  - Sequences the SRAM strobes E_b/WE_b.
//  - Captures read data; the SRAM output is high-Z whenever it is not selected for read.
//  - Sits between the requesters and the ims1420 instance; that instance shares clk.
// PARAMETERS
//  NUM_REQ  2   number of requester ports (2..4)
//  ADDR_W   12  SRAM address width
//  DATA_W   4   SRAM data width
// PORTS
//  clk       in   1                 system clock; the SRAM write also commits on posedge clk
//  rst_b     in   1                 asynchronous reset, active low
//  req       in   NUM_REQ           per-port request; held with we/addr/wdata until ack
//  we        in   NUM_REQ           per-port 1=write, 0=read
//  addr      in   NUM_REQ*ADDR_W    per-port address, packed [NUM_REQ-1:0][ADDR_W-1:0]
//  wdata     in   NUM_REQ*DATA_W    per-port write data, packed
//  ack       out  NUM_REQ           one-cycle completion pulse for the granted port
//  rdata     out  DATA_W            read result; valid in the cycle ack is high
//  busy      out  1                 1 while in state ACCESS or RESP
//  ram_addr  out  ADDR_W            to SRAM ADDR
//  ram_din   out  DATA_W            to SRAM DATA_IN
//  ram_dout  in   DATA_W            from SRAM DATA_OUT (may be Z)
//  ram_we_b  out  1                 SRAM write enable, active low
//  ram_e_b   out  1                 SRAM chip enable, active low
// BEHAVIOUR
//  - FSM: IDLE -> ACCESS -> RESP -> IDLE. One access per 3 cycles. Every output is registered.
//  - Reset values:
//    - state=IDLE, ack=0, rdata=0, busy=0.
//    - ram_e_b=1, ram_we_b=1, ram_addr=0, ram_din=0.
//    - rr pointer selects port 0 as highest priority.
//  - IDLE:
//    - If any req is high, pick the winner by round-robin; priority starts at the port after
//      the last grant.
//    - Latch the winner's index, we, addr and wdata. Drive ram_e_b=0 and ram_we_b=~we.
//      Go to ACCESS.
//    - If no req is high, stay in IDLE with the strobes high.
//  - ACCESS (exactly 1 cycle):
//    - Strobes and ram_addr/ram_din are stable.
//    - Write: the SRAM commits on the closing edge.
//    - Read: rdata <= ram_dout on the closing edge.
//    - On the closing edge set ram_e_b=ram_we_b=1, pulse ack[winner], go to RESP.
//  - RESP: ack[winner]=1 for this cycle only; the rr pointer updates to the winner; go to IDLE.
//  - Latency: req seen in IDLE at edge N -> ack high in cycle N+2.
//  - rdata holds its value until the next read completes. Writes leave rdata unchanged.
//  - The requester must drop req by the edge that ends the ack cycle. A req still high in IDLE
//    is a new request and repeats the access.
//  - req dropped after grant: the latched transaction still completes and ack still pulses.
//    Signals from unselected ports are ignored.
//  - ram_dout is sampled only at the ACCESS edge of a read; Z/X at other times has no effect.
//  - ram_we_b is never low while ram_e_b is high. The strobes never change except at an edge.
//  - Asynchronous reset mid-operation:
//    - Strobes go high immediately; no write commits at the next edge.
//    - ack is cleared; the pending transaction is dropped with no ack.
// STRUCTURE
//  - Package ims1420_ctrl_pkg holds: state_t enum {IDLE, ACCESS, RESP}; the ADDR_W/DATA_W
//    default constants; typedef req_t {we, addr, wdata}.
//  - Sub-module rr_arbiter(#NUM_REQ):
//    - Combinational one-hot grant from req and last_gnt.
//    - Registered pointer, updated on the upd strobe (asserted in RESP).
//  - Top level holds the FSM, the transaction latch and the rdata capture.
// TESTING
//  1. Write then read, port 0:
//     - wr 0x123=0xA -> ack[0] at N+2.
//     - rd 0x123 -> ack[0] with rdata=0xA.
//     - ram_e_b low only during ACCESS.
//  2. Simultaneous req after reset: P0 writes 0x010=0x3, P1 writes 0x011=0x5.
//     - P0 is served first, then P1.
//     - A repeated simultaneous pair is served P0 then P1 again (rotation).
//     - Readback returns 3 and 5.
//  3. Port 1 holds req high for 1 extra cycle after ack[1] -> a second identical access
//     occurs with a second ack.
//  4. Port 0 drops req in the cycle after grant -> the access still completes;
//     ack[0] pulses at N+2.
//  5. Assert rst_b low during ACCESS of a write 0x200=0xF:
//     - ram_e_b/ram_we_b go high asynchronously; no ack.
//     - After release, read 0x200 -> the prior contents.
//  6. Back-to-back reads from 2 ports with ram_dout forced Z outside ACCESS
//     -> rdata is correct at each ack and never X.

Source files
------------

// File: rtl/ims1420_ctrl_pkg.sv
// ims1420 SRAM arbiter: shared types and constants.
// FSM states, default bus widths and the request bundle.
package ims1420_ctrl_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the ims1420 SRAM ports.
// Combinational grant; pointer holds the last served port.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_i,
  input  logic [IDX_W-1:0]   upd_idx_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;

  // pointer = last grant; reset makes port 0 the first candidate
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (upd_i) begin
      ptr_q <= upd_idx_i;
    end
  end

  // scan from farthest to nearest so the port right after ptr wins
  always_comb begin
    cand      = '0;
    any_o     = 1'b0;
    gnt_idx_o = '0;
    gnt_o     = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr_q) + off) % NUM_REQ);
      if (req_i[cand]) begin
        any_o     = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (any_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/ims1420_arbiter.sv
// Shares one ims1420 4Kx4 SRAM between NUM_REQ requesters.
// IDLE -> ACCESS -> RESP; all outputs come straight from flops.
module ims1420_arbiter
  import ims1420_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_W-1:0]              rdata,
  output logic                           busy,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_din,
  input  logic [DATA_W-1:0]              ram_dout,
  output logic                           ram_we_b,
  output logic                           ram_e_b
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t state_q, state_d;

  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_din_q, ram_din_d;
  logic               ram_we_b_q, ram_we_b_d;
  logic               ram_e_b_q, ram_e_b_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;

  logic               any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               upd;

  assign upd = (state_q == RESP);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst_b    (rst_b),
    .req_i    (req),
    .upd_i    (upd),
    .upd_idx_i(win_idx_q),
    .any_o    (any),
    .gnt_idx_o(gnt_idx),
    .gnt_o    (gnt)
  );

  // state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // fixed three-step walk; only IDLE waits on a request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // strobes default high so they drop only for the ACCESS cycle
  always_comb begin
    win_idx_d  = win_idx_q;
    win_oh_d   = win_oh_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_e_b_d  = 1'b1;
    ram_we_b_d = 1'b1;
    ack_d      = '0;
    rdata_d    = rdata_q;
    busy_d     = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (any) begin
          win_idx_d  = gnt_idx;
          win_oh_d   = gnt;
          ram_addr_d = addr[gnt_idx];
          ram_din_d  = wdata[gnt_idx];
          ram_e_b_d  = 1'b0;
          ram_we_b_d = ~we[gnt_idx];
        end
      end
      ACCESS: begin
        ack_d = win_oh_q;
        if (ram_we_b_q) begin
          rdata_d = ram_dout;
        end
      end
      default: ;
    endcase
  end

  // output and transaction-latch registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      win_idx_q  <= '0;
      win_oh_q   <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_e_b_q  <= 1'b1;
      ram_we_b_q <= 1'b1;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      win_idx_q  <= win_idx_d;
      win_oh_q   <= win_oh_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_e_b_q  <= ram_e_b_d;
      ram_we_b_q <= ram_we_b_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_e_b  = ram_e_b_q;
  assign ram_we_b = ram_we_b_q;

endmodule
